grf_writeback: RTL and testbench
================================

Name: grf_writeback

Overview:
- W-stage pipeline register and write-port driver for the general register file (GRF).
- Latches the M-stage result each cycle, then selects the write-back source: ALU result, extended load data, or link address.
- Drives the GRF write port (a3/wd/pc) and the W-stage forwarding bus.
- Guarantees each retired instruction writes the GRF exactly once, even when the W register is held.

Parameters:
- RESET_PC, 32'h0000_3000, value of grf_pc and w_pc after reset.
- LINK_OFFSET, 32'd8, added to the instruction PC for link-type write-back (jal/jalr).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; clears W register.
- w_stall  input  1  hold W register contents this cycle.
- w_flush  input  1  load a bubble into W register (ignored while w_stall=1).
- m_valid  input  1  M-stage slot holds a real instruction.
- m_pc  input  32  PC of M-stage instruction.
- m_a3  input  5  destination register; 0 = no write.
- m_wdsel  input  2  0=ALU, 1=MEM, 2=LINK, 3=reserved (treated as ALU).
- m_alu_res  input  32  ALU result.
- m_dm_rdata  input  32  raw word read from data memory.
- m_addr_lo  input  2  low bits of the effective address.
- m_ld_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; others treated as LW.
- grf_a3  output  5  GRF write address; 0 = no write.
- grf_wd  output  32  GRF write data.
- grf_pc  output  32  PC of the writing instruction (for the trace).
- w_fwd_a3  output  5  destination address for forwarding muxes, equal to the latched a3 of a valid slot (independent of the commit flag).
- w_fwd_data  output  32  forwarded value, always equal to grf_wd.
- retired  output  32  count of committed valid instructions.

Behaviour:
- Reset: W register cleared, so valid=0, a3=0, data=0, pc=RESET_PC.
  - Outputs after reset: grf_a3=0, grf_wd=0, grf_pc=RESET_PC, w_fwd_a3=0, retired=0, committed flag=0.
- Register update priority per posedge: reset > w_stall (hold) > w_flush (bubble: valid=0, a3=0, pc=RESET_PC) > load M-stage fields.
- Write data is computed in M→W registration, so the W-stage output is purely registered. Latency is 1 cycle from the M-stage inputs to grf_* outputs.
- Source selection:
  - ALU: m_alu_res.
  - LINK: m_pc + LINK_OFFSET, mod 2^32 (wraps).
  - MEM: extended load data:
    - LW: whole word; m_addr_lo is ignored.
    - LH/LHU: halfword selected by m_addr_lo[1] (0 → bits 15:0, 1 → bits 31:16); sign- or zero-extended to 32 bits; m_addr_lo[0] is ignored.
    - LB/LBU: byte selected by m_addr_lo (00 → bits 7:0 … 11 → bits 31:24); sign- or zero-extended to 32 bits.
- $0 rule: if m_a3=0 or m_valid=0, the latched a3 is 0 and the slot never writes; the data field is still latched.
- Commit flag:
  - Set at the end of the first cycle a valid slot with a3≠0 is presented.
  - While the flag is set, grf_a3 is forced to 0, so a held slot writes only once.
  - The flag clears whenever a new slot is loaded (flush or normal load).
- retired: increments by 1 in the first presented cycle of each valid slot, including a3=0 slots. It does not increment on repeat cycles of a held slot or on bubbles. Wraps at 2^32.
- Simultaneous w_stall and w_flush: the stall wins; the flush is dropped; the bench checks no write is lost.
- Reset asserted while a slot is held: the slot is discarded and no write occurs in the reset cycle's successor.

Decomposition:
- Shared pipeline package:
  - WDSEL_ALU/MEM/LINK encodings.
  - LD_LW/LH/LHU/LB/LBU encodings.
  - RESET_PC default.
- Sub-module load_ext (combinational: rdata, addr_lo, ld_type → extended word); the D-cache path reuses it later.
- Everything else stays in grf_writeback.

Test Plan:
- Reset, then m_valid=1, m_a3=5, m_wdsel=ALU, m_alu_res=32'h1234_5678, m_pc=32'h3004 → next cycle grf_a3=5, grf_wd=32'h1234_5678, grf_pc=32'h3004, retired=1.
- LB, m_dm_rdata=32'h80FF_7F01, m_addr_lo=3 → grf_wd=32'hFFFF_FF80. Same input with LBU → 32'h0000_0080. LH with m_addr_lo=2 → 32'hFFFF_80FF. LHU with m_addr_lo=0 → 32'h0000_7F01.
- LINK with m_pc=32'h0000_3010, m_a3=31 → grf_wd=32'h0000_3018. LINK with m_pc=32'hFFFF_FFFC → grf_wd=32'h0000_0004.
- Valid slot a3=7 presented, then w_stall=1 for 3 cycles → grf_a3=7 in the first cycle only, 0 for the next 3 cycles; w_fwd_a3 stays 7 throughout; retired increases by 1.
- m_a3=0 with m_valid=1 → grf_a3=0 and retired increments. w_flush=1 → grf_a3=0, grf_pc=32'h3000, retired unchanged. w_stall=1 and w_flush=1 together → the held slot is retained.
- Mid-hold reset=1 → next cycle all outputs at reset values, retired=0, and no write occurs.

Source files
------------

// File: rtl/grf_writeback_pkg.sv
// Shared pipeline encodings for the write-back stage and the load-extension logic.
package grf_writeback_pkg;

  typedef enum logic [1:0] {
    WDSEL_ALU  = 2'd0,
    WDSEL_MEM  = 2'd1,
    WDSEL_LINK = 2'd2,
    WDSEL_RSVD = 2'd3
  } wdsel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_type_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/grf_writeback_load_ext.sv
// Combinational load-data extractor: picks the addressed byte/halfword and extends it.
module grf_writeback_load_ext
  import grf_writeback_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_ld_type,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  always_comb begin
    case (i_ld_type)
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/grf_writeback.sv
// W-stage pipeline register: latches the selected write-back value and drives the GRF
// write port once per retired instruction, even across stalls.
module grf_writeback
  import grf_writeback_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_w_stall,
  input  logic        i_w_flush,
  input  logic        i_m_valid,
  input  logic [31:0] i_m_pc,
  input  logic [4:0]  i_m_a3,
  input  logic [1:0]  i_m_wdsel,
  input  logic [31:0] i_m_alu_res,
  input  logic [31:0] i_m_dm_rdata,
  input  logic [1:0]  i_m_addr_lo,
  input  logic [2:0]  i_m_ld_type,
  output logic [4:0]  o_grf_a3,
  output logic [31:0] o_grf_wd,
  output logic [31:0] o_grf_pc,
  output logic [4:0]  o_w_fwd_a3,
  output logic [31:0] o_w_fwd_data,
  output logic [31:0] o_retired
);

  logic [31:0] w_ext_data;
  logic [31:0] w_wd_next;
  logic [4:0]  w_a3_next;

  logic        r_valid;
  logic [4:0]  r_a3;
  logic [31:0] r_data;
  logic [31:0] r_pc;
  logic        r_committed;
  logic [31:0] r_retired;

  grf_writeback_load_ext u_load_ext (
    .i_rdata   (i_m_dm_rdata),
    .i_addr_lo (i_m_addr_lo),
    .i_ld_type (i_m_ld_type),
    .o_data    (w_ext_data)
  );

  always_comb begin
    case (i_m_wdsel)
      WDSEL_MEM:  w_wd_next = w_ext_data;
      WDSEL_LINK: w_wd_next = i_m_pc + LINK_OFFSET;
      default:    w_wd_next = i_m_alu_res;
    endcase
    // Invalid slots and $0 targets latch a3=0 so they can never write.
    w_a3_next = i_m_valid ? i_m_a3 : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_a3        <= 5'd0;
      r_data      <= 32'd0;
      r_pc        <= RESET_PC;
      r_committed <= 1'b0;
      r_retired   <= 32'd0;
    end else if (i_w_stall) begin
      // Once a held slot has been presented, suppress further writes from it.
      r_committed <= r_committed | (r_valid && (r_a3 != 5'd0));
    end else if (i_w_flush) begin
      r_valid     <= 1'b0;
      r_a3        <= 5'd0;
      r_data      <= 32'd0;
      r_pc        <= RESET_PC;
      r_committed <= 1'b0;
    end else begin
      r_valid     <= i_m_valid;
      r_a3        <= w_a3_next;
      r_data      <= w_wd_next;
      r_pc        <= i_m_pc;
      r_committed <= 1'b0;
      r_retired   <= r_retired + {31'd0, i_m_valid};
    end
  end

  assign o_grf_a3     = r_committed ? 5'd0 : r_a3;
  assign o_grf_wd     = r_data;
  assign o_grf_pc     = r_pc;
  assign o_w_fwd_a3   = r_a3;
  assign o_w_fwd_data = r_data;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_grf_writeback.sv
// Directed bench for grf_writeback: expected W-stage outputs are queued when each
// M-stage slot is driven and compared one cycle later.
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic        w_stall;
  logic        w_flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_a3;
  logic [1:0]  m_wdsel;
  logic [31:0] m_alu_res;
  logic [31:0] m_dm_rdata;
  logic [1:0]  m_addr_lo;
  logic [2:0]  m_ld_type;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [4:0]  w_fwd_a3;
  logic [31:0] w_fwd_data;
  logic [31:0] retired;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  fwd;
    logic [31:0] ret;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  grf_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .i_w_stall    (w_stall),
    .i_w_flush    (w_flush),
    .i_m_valid    (m_valid),
    .i_m_pc       (m_pc),
    .i_m_a3       (m_a3),
    .i_m_wdsel    (m_wdsel),
    .i_m_alu_res  (m_alu_res),
    .i_m_dm_rdata (m_dm_rdata),
    .i_m_addr_lo  (m_addr_lo),
    .i_m_ld_type  (m_ld_type),
    .o_grf_a3     (grf_a3),
    .o_grf_wd     (grf_wd),
    .o_grf_pc     (grf_pc),
    .o_w_fwd_a3   (w_fwd_a3),
    .o_w_fwd_data (w_fwd_data),
    .o_retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [1:0] lo, input logic [2:0] ld);
    m_valid    = v;
    m_pc       = pc;
    m_a3       = a3;
    m_wdsel    = sel;
    m_alu_res  = alu;
    m_dm_rdata = rdata;
    m_addr_lo  = lo;
    m_ld_type  = ld;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] a3, input logic [31:0] wd,
                            input logic [31:0] pc, input logic [4:0] fwd,
                            input logic [31:0] ret);
    exp_t e;
    e.a3  = a3;
    e.wd  = wd;
    e.pc  = pc;
    e.fwd = fwd;
    e.ret = ret;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one clock, then pop the oldest expectation and compare every output.
  task automatic step();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks += 6;
      assert (grf_a3 === e.a3) else begin
        n_errors++;
        $error("FAIL %s grf_a3 observed=%0d expected=%0d", t, grf_a3, e.a3);
      end
      assert (grf_wd === e.wd) else begin
        n_errors++;
        $error("FAIL %s grf_wd observed=%h expected=%h", t, grf_wd, e.wd);
      end
      assert (grf_pc === e.pc) else begin
        n_errors++;
        $error("FAIL %s grf_pc observed=%h expected=%h", t, grf_pc, e.pc);
      end
      assert (w_fwd_a3 === e.fwd) else begin
        n_errors++;
        $error("FAIL %s w_fwd_a3 observed=%0d expected=%0d", t, w_fwd_a3, e.fwd);
      end
      assert (w_fwd_data === e.wd) else begin
        n_errors++;
        $error("FAIL %s w_fwd_data observed=%h expected=%h", t, w_fwd_data, e.wd);
      end
      assert (retired === e.ret) else begin
        n_errors++;
        $error("FAIL %s retired observed=%0d expected=%0d", t, retired, e.ret);
      end
    end
  endtask

  initial begin
    logic [31:0] ret_m;
    logic [31:0] rv;
    logic [4:0]  ra;

    reset   = 1'b1;
    w_stall = 1'b0;
    w_flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 2'd0, 3'd0);
    @(posedge clk);
    expect_out("reset", 5'd0, 32'h0, 32'h3000, 5'd0, 32'd0);
    step();

    reset = 1'b0;
    drive(1'b1, 32'h3004, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 2'd0, 3'd0);
    expect_out("alu", 5'd5, 32'h1234_5678, 32'h3004, 5'd5, 32'd1);
    step();

    drive(1'b1, 32'h3008, 5'd1, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'd3, 3'd3);
    expect_out("lb_hi", 5'd1, 32'hFFFF_FF80, 32'h3008, 5'd1, 32'd2);
    step();
    drive(1'b1, 32'h300C, 5'd2, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'd3, 3'd4);
    expect_out("lbu_hi", 5'd2, 32'h0000_0080, 32'h300C, 5'd2, 32'd3);
    step();
    drive(1'b1, 32'h3010, 5'd3, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'd2, 3'd1);
    expect_out("lh_hi", 5'd3, 32'hFFFF_80FF, 32'h3010, 5'd3, 32'd4);
    step();
    drive(1'b1, 32'h3014, 5'd4, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'd0, 3'd2);
    expect_out("lhu_lo", 5'd4, 32'h0000_7F01, 32'h3014, 5'd4, 32'd5);
    step();
    drive(1'b1, 32'h3018, 5'd6, 2'd1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'd1, 3'd0);
    expect_out("lw", 5'd6, 32'h80FF_7F01, 32'h3018, 5'd6, 32'd6);
    step();

    drive(1'b1, 32'h0000_3010, 5'd31, 2'd2, 32'h0, 32'h0, 2'd0, 3'd0);
    expect_out("link", 5'd31, 32'h0000_3018, 32'h0000_3010, 5'd31, 32'd7);
    step();
    drive(1'b1, 32'hFFFF_FFFC, 5'd31, 2'd2, 32'h0, 32'h0, 2'd0, 3'd0);
    expect_out("link_wrap", 5'd31, 32'h0000_0004, 32'hFFFF_FFFC, 5'd31, 32'd8);
    step();
    drive(1'b1, 32'h301C, 5'd8, 2'd3, 32'h0BAD_F00D, 32'h1111_1111, 2'd0, 3'd0);
    expect_out("rsvd_alu", 5'd8, 32'h0BAD_F00D, 32'h301C, 5'd8, 32'd9);
    step();

    drive(1'b1, 32'h3020, 5'd7, 2'd0, 32'hAAAA_0007, 32'h0, 2'd0, 3'd0);
    expect_out("hold_first", 5'd7, 32'hAAAA_0007, 32'h3020, 5'd7, 32'd10);
    step();
    w_stall = 1'b1;
    drive(1'b1, 32'h4000, 5'd9, 2'd0, 32'h5555_5555, 32'h0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      expect_out("hold_repeat", 5'd0, 32'hAAAA_0007, 32'h3020, 5'd7, 32'd10);
      step();
    end
    w_stall = 1'b0;

    drive(1'b1, 32'h3030, 5'd0, 2'd0, 32'h0000_5555, 32'h0, 2'd0, 3'd0);
    expect_out("a3_zero", 5'd0, 32'h0000_5555, 32'h3030, 5'd0, 32'd11);
    step();
    drive(1'b0, 32'h3034, 5'd3, 2'd0, 32'h0000_0077, 32'h0, 2'd0, 3'd0);
    expect_out("invalid", 5'd0, 32'h0000_0077, 32'h3034, 5'd0, 32'd11);
    step();
    w_flush = 1'b1;
    drive(1'b1, 32'h3038, 5'd4, 2'd0, 32'h0000_0099, 32'h0, 2'd0, 3'd0);
    expect_out("flush", 5'd0, 32'h0, 32'h3000, 5'd0, 32'd11);
    step();
    w_flush = 1'b0;

    drive(1'b1, 32'h3040, 5'd12, 2'd0, 32'h0000_0C0C, 32'h0, 2'd0, 3'd0);
    expect_out("pre_stall_flush", 5'd12, 32'h0000_0C0C, 32'h3040, 5'd12, 32'd12);
    step();
    w_stall = 1'b1;
    w_flush = 1'b1;
    drive(1'b1, 32'h3044, 5'd14, 2'd0, 32'h0000_0E0E, 32'h0, 2'd0, 3'd0);
    expect_out("stall_flush", 5'd0, 32'h0000_0C0C, 32'h3040, 5'd12, 32'd12);
    step();
    w_stall = 1'b0;
    w_flush = 1'b0;
    drive(1'b1, 32'h3044, 5'd14, 2'd0, 32'h0000_0E0E, 32'h0, 2'd0, 3'd0);
    expect_out("after_stall_flush", 5'd14, 32'h0000_0E0E, 32'h3044, 5'd14, 32'd13);
    step();

    drive(1'b1, 32'h3060, 5'd13, 2'd0, 32'h0000_1313, 32'h0, 2'd0, 3'd0);
    expect_out("pre_reset_hold", 5'd13, 32'h0000_1313, 32'h3060, 5'd13, 32'd14);
    step();
    w_stall = 1'b1;
    expect_out("reset_hold", 5'd0, 32'h0000_1313, 32'h3060, 5'd13, 32'd14);
    step();
    reset = 1'b1;
    expect_out("mid_hold_reset", 5'd0, 32'h0, 32'h3000, 5'd0, 32'd0);
    step();
    reset = 1'b0;
    expect_out("post_reset_held", 5'd0, 32'h0, 32'h3000, 5'd0, 32'd0);
    step();
    w_stall = 1'b0;

    // Back-to-back random ALU slots against a running retire count.
    ret_m = 32'd0;
    for (int i = 0; i < 8; i++) begin
      rv = $urandom;
      ra = 5'($urandom_range(1, 31));
      drive(1'b1, 32'h5000 + 32'(i * 4), ra, 2'd0, rv, 32'h0, 2'd0, 3'd0);
      ret_m = ret_m + 32'd1;
      expect_out("rand_alu", ra, rv, 32'h5000 + 32'(i * 4), ra, ret_m);
      step();
    end

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
